seq_pattern_gen: RTL and testbench



---
 rtl/seq_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial pattern generator that emits a latched pattern MSB-first,
//            repeated N times with an idle gap, over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeats,
    input  logic [GAP_W-1:0] gap,
    input  logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] c_rep_one  = CNT_W'(1);
    localparam logic [GAP_W-1:0] c_gap_one  = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic out_q, out_d;
    logic out_valid_q, out_valid_d;
    logic frame_start_q, frame_start_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            // DONE behaves like IDLE for command acceptance, so back-to-back
            // commands need no idle cycle in between.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    pat_d     = pattern;
                    rep_d     = repeats;
                    gap_len_d = gap;
                    idx_d     = c_idx_last;
                    gap_cnt_d = '0;
                    state_d   = (repeats == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ready) begin
                    if (idx_q == '0) begin
                        rep_d = rep_q - c_rep_one;
                        idx_d = c_idx_last;
                        if (rep_q == c_rep_one) begin
                            state_d = S_DONE;
                        end else if (gap_len_q == '0) begin
                            state_d = S_SHIFT;
                        end else begin
                            gap_cnt_d = gap_len_q;
                            state_d   = S_GAP;
                        end
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == c_gap_one) begin
                    gap_cnt_d = '0;
                    idx_d     = c_idx_last;
                    state_d   = S_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - c_gap_one;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency; a stall leaves them unchanged.
    always_comb begin
        out_d         = 1'b0;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        case (state_d)
            S_SHIFT: begin
                out_d         = pat_d[idx_d];
                out_valid_d   = 1'b1;
                frame_start_d = (idx_d == c_idx_last);
                busy_d        = 1'b1;
            end
            S_GAP:   busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pat_q         <= '0;
            idx_q         <= '0;
            rep_q         <= '0;
            gap_len_q     <= '0;
            gap_cnt_q     <= '0;
            out_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pat_q         <= pat_d;
            idx_q         <= idx_d;
            rep_q         <= rep_d;
            gap_len_q     <= gap_len_d;
            gap_cnt_q     <= gap_cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Brief    : Directed self-checking bench for seq_pattern_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] pattern;
    logic [3:0] repeats;
    logic [1:0] gap;
    logic       ready;
    logic       out;
    logic       out_valid;
    logic       frame_start;
    logic       busy;
    logic       done;

    int n_asserts = 0;
    int n_fail    = 0;

    // Per-cycle vector: {reset, start, ready, out, out_valid, frame_start, busy, done}
    logic [7:0] vec [$];

    seq_pattern_gen #(
        .PAT_W(3),
        .CNT_W(4),
        .GAP_W(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .repeats    (repeats),
        .gap        (gap),
        .ready      (ready),
        .out        (out),
        .out_valid  (out_valid),
        .frame_start(frame_start),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed={o,v,f,b,d}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Issues a command; on return the bench is in cycle 1 of that command.
    task automatic go(input logic [2:0] p, input logic [3:0] r, input logic [1:0] g);
        pattern = p;
        repeats = r;
        gap     = g;
        ready   = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic run(input string tag);
        for (int i = 0; i < vec.size(); i++) begin
            {reset, start, ready} = vec[i][7:5];
            chk($sformatf("%s_c%0d", tag, i + 1),
                {out, out_valid, frame_start, busy, done}, vec[i][4:0]);
            step();
        end
        reset = 1'b0;
        start = 1'b0;
        ready = 1'b1;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        repeats = '0;
        gap     = '0;
        ready   = 1'b1;
        step();
        step();
        chk("reset", {out, out_valid, frame_start, busy, done}, 5'b00000);
        reset = 1'b0;
        step();
        chk("idle", {out, out_valid, frame_start, busy, done}, 5'b00000);

        // 101 x2, no gap: overlapping stream 101101
        go(3'b101, 4'd2, 2'd0);
        vec = '{8'b001_11110, 8'b001_01010, 8'b001_11010, 8'b001_11110,
                8'b001_01010, 8'b001_11010, 8'b001_00001, 8'b001_00000};
        run("b2b");

        // 110 x2 with two idle cycles between repetitions
        go(3'b110, 4'd2, 2'd2);
        vec = '{8'b001_11110, 8'b001_11010, 8'b001_01010, 8'b001_00010,
                8'b001_00010, 8'b001_11110, 8'b001_11010, 8'b001_01010,
                8'b001_00001, 8'b001_00000};
        run("gap2");

        // 101 x1, ready low in cycles 2-4 holds the middle bit
        go(3'b101, 4'd1, 2'd0);
        vec = '{8'b001_11110, 8'b000_01010, 8'b000_01010, 8'b000_01010,
                8'b001_01010, 8'b001_11010, 8'b001_00001, 8'b001_00000};
        run("stall");

        // Stall on the first bit keeps frame_start asserted
        go(3'b010, 4'd1, 2'd0);
        vec = '{8'b000_01110, 8'b000_01110, 8'b001_01110, 8'b001_11010,
                8'b001_01010, 8'b001_00001, 8'b001_00000};
        run("stall_msb");

        // Zero repeats: straight to DONE, no valid bits
        go(3'b111, 4'd0, 2'd1);
        vec = '{8'b001_00001, 8'b001_00000, 8'b001_00000};
        run("rep0");

        // 101 x3 gap 1; starts with new parameters while busy are ignored
        go(3'b101, 4'd3, 2'd1);
        pattern = 3'b010;
        repeats = 4'd5;
        gap     = 2'd0;
        vec = '{8'b001_11110, 8'b011_01010, 8'b011_11010, 8'b001_00010,
                8'b001_11110, 8'b001_01010, 8'b001_11010, 8'b011_00010,
                8'b001_11110, 8'b001_01010, 8'b001_11010, 8'b001_00001,
                8'b001_00000};
        run("busy_start");

        // Start during DONE is accepted with no intervening idle cycle
        go(3'b101, 4'd1, 2'd0);
        pattern = 3'b011;
        repeats = 4'd1;
        gap     = 2'd0;
        vec = '{8'b001_11110, 8'b001_01010, 8'b001_11010, 8'b011_00001,
                8'b001_01110, 8'b001_11010, 8'b001_11010, 8'b001_00001,
                8'b001_00000};
        run("done_start");

        // Reset in cycle 3 of a 2-repeat run: outputs clear, no done pulse
        go(3'b110, 4'd2, 2'd0);
        vec = '{8'b001_11110, 8'b001_11010, 8'b111_01010, 8'b001_00000,
                8'b001_00000, 8'b001_00000, 8'b001_00000};
        run("mid_reset");

        // After reset the generator behaves as from power-up
        go(3'b101, 4'd2, 2'd0);
        vec = '{8'b001_11110, 8'b001_01010, 8'b001_11010, 8'b001_11110,
                8'b001_01010, 8'b001_11010, 8'b001_00001, 8'b001_00000};
        run("post_reset");

        // Maximum gap of 3 cycles
        go(3'b100, 4'd2, 2'd3);
        vec = '{8'b001_11110, 8'b001_01010, 8'b001_01010, 8'b001_00010,
                8'b001_00010, 8'b001_00010, 8'b001_11110, 8'b001_01010,
                8'b001_01010, 8'b001_00001, 8'b001_00000};
        run("gap3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
